// File: rtl/arb_pkg.sv
// Shared types and helpers for the round-robin grant encoder.
// Provides the arbiter state type and a generic one-hot to binary encoder.
package arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    localparam int unsigned ARB_IDLE_IDX = 0;

    // OR of the indices of all set bits; exact for zero or one-hot inputs.
    function automatic int unsigned onehot_to_idx(input logic [63:0] i_oh);
        int unsigned v;
        v = ARB_IDLE_IDX;
        for (int unsigned i = 0; i < 64; i++) begin
            if (i_oh[i]) v = v | i;
        end
        return v;
    endfunction

endpackage

// File: rtl/rr_pick.sv
// Rotating-priority search: first set request after i_last_idx, wrapping
// from N_REQ-1 back to 0.
module rr_pick #(
    parameter int N_REQ = 4,
    parameter int IDX_W = 2
) (
    input  logic [N_REQ-1:0] i_req,
    input  logic [IDX_W-1:0] i_last_idx,
    output logic             o_found,
    output logic [IDX_W-1:0] o_win_idx
);

    always_comb begin
        int         pos_int;
        logic [IDX_W-1:0] w_pos;
        o_found   = 1'b0;
        o_win_idx = '0;
        pos_int   = 0;
        w_pos     = '0;
        // Scan farthest-first so the closest candidate after last_idx overwrites.
        for (int k = N_REQ - 1; k >= 0; k--) begin
            pos_int = int'(i_last_idx) + 1 + k;
            if (pos_int >= N_REQ) pos_int = pos_int - N_REQ;
            w_pos = IDX_W'(pos_int);
            if (i_req[w_pos]) begin
                o_found   = 1'b1;
                o_win_idx = w_pos;
            end
        end
    end

endmodule

// File: rtl/rr_grant_encoder.sv
// Round-robin arbiter with grant hold timeout and binary grant index.
// state | meaning
// IDLE  | no grant; arbitrate among pending requests, grant on next edge
// BUSY  | grant held for owner until its request drops or MAX_HOLD expires
module rr_grant_encoder
    import arb_pkg::*;
#(
    parameter int N_REQ    = 4,
    parameter int IDX_W    = 2,
    parameter int MAX_HOLD = 16,
    parameter int CNT_W    = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [N_REQ-1:0] i_req,
    output logic [N_REQ-1:0] o_grant,
    output logic [IDX_W-1:0] o_grant_idx,
    output logic             o_grant_valid,
    output logic             o_timeout
);

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_hold_cnt;
    logic [IDX_W-1:0] r_last_idx;
    logic [N_REQ-1:0] r_grant;
    logic             r_grant_valid;
    logic             r_timeout;

    logic             w_found;
    logic [IDX_W-1:0] w_win_idx;
    logic [IDX_W-1:0] w_owner_idx;
    logic             w_owner_req;
    logic [N_REQ-1:0] w_onehot;

    rr_pick #(
        .N_REQ (N_REQ),
        .IDX_W (IDX_W)
    ) u_pick (
        .i_req      (i_req),
        .i_last_idx (r_last_idx),
        .o_found    (w_found),
        .o_win_idx  (w_win_idx)
    );

    assign w_onehot    = N_REQ'(1) << w_win_idx;
    assign w_owner_idx = IDX_W'(onehot_to_idx(64'(r_grant)));
    assign w_owner_req = i_req[w_owner_idx];

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state       <= IDLE;
            r_hold_cnt    <= '0;
            r_last_idx    <= IDX_W'(N_REQ - 1);
            r_grant       <= '0;
            r_grant_valid <= 1'b0;
            r_timeout     <= 1'b0;
        end else begin
            r_timeout <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_grant       <= w_onehot;
                        r_grant_valid <= 1'b1;
                        r_hold_cnt    <= '0;
                        r_state       <= BUSY;
                    end
                end
                BUSY: begin
                    // Release wins over timeout when both apply in the same cycle.
                    if (!w_owner_req) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_last_idx    <= w_owner_idx;
                        r_state       <= IDLE;
                    end else if (r_hold_cnt == CNT_W'(MAX_HOLD - 1)) begin
                        r_grant       <= '0;
                        r_grant_valid <= 1'b0;
                        r_last_idx    <= w_owner_idx;
                        r_timeout     <= 1'b1;
                        r_state       <= IDLE;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + CNT_W'(1);
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign o_grant       = r_grant;
    assign o_grant_idx   = w_owner_idx;
    assign o_grant_valid = r_grant_valid;
    assign o_timeout     = r_timeout;

endmodule

// File: tb/tb_rr_grant_encoder.sv
// Directed bench for rr_grant_encoder: reset, single grant, rotation,
// hold timeout, fairness, release at the hold limit and reset mid-grant.
module tb_rr_grant_encoder;

    logic       clk;
    logic       rst;
    logic [3:0] req;
    logic [3:0] grant;
    logic [1:0] grant_idx;
    logic       grant_valid;
    logic       timeout;

    int tests_run = 0;
    int tests_failed = 0;

    rr_grant_encoder #(
        .N_REQ    (4),
        .IDX_W    (2),
        .MAX_HOLD (16),
        .CNT_W    (5)
    ) dut (
        .i_clk         (clk),
        .i_rst         (rst),
        .i_req         (req),
        .o_grant       (grant),
        .o_grant_idx   (grant_idx),
        .o_grant_valid (grant_valid),
        .o_timeout     (timeout)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        req = 4'b0000;
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        req = 4'b0000;
        repeat (3) @(negedge clk);
        tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL reset_grant: got %b expected 0000", grant); end
        tests_run++; if (grant_idx !== 2'd0) begin tests_failed++; $display("FAIL reset_idx: got %0d expected 0", grant_idx); end
        tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL reset_valid: got %b expected 0", grant_valid); end
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL reset_timeout: got %b expected 0", timeout); end
        rst = 1'b0;
        @(negedge clk);
        tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL idle_no_req: got valid %b expected 0", grant_valid); end
    endtask

    task automatic test_single();
        req = 4'b0001;
        @(negedge clk);
        tests_run++; if (grant !== 4'b0001) begin tests_failed++; $display("FAIL single_grant: got %b expected 0001", grant); end
        tests_run++; if (grant_idx !== 2'd0) begin tests_failed++; $display("FAIL single_idx: got %0d expected 0", grant_idx); end
        tests_run++; if (grant_valid !== 1'b1) begin tests_failed++; $display("FAIL single_valid: got %b expected 1", grant_valid); end
        req = 4'b0000;
        @(negedge clk);
        tests_run++; if (grant_valid !== 1'b0) begin tests_failed++; $display("FAIL single_release_valid: got %b expected 0", grant_valid); end
        tests_run++; if (grant !== 4'b0000) begin tests_failed++; $display("FAIL single_release_grant: got %b expected 0000", grant); end
    endtask

    task automatic test_rotation();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [3:0] exp_oh;
        do_reset();
        req = 4'b1111;
        for (int n = 0; n < 5; n++) begin
            exp_oh = 4'b0001 << order[n];
            for (int c = 0; c < 3; c++) begin
                @(negedge clk);
                tests_run++; if (grant !== exp_oh || grant_idx !== 2'(order[n]) || grant_valid !== 1'b1) begin
                    tests_failed++;
                    $display("FAIL rotation_grant[%0d] cyc %0d: got grant %b idx %0d valid %b expected grant %b idx %0d valid 1",
                             n, c, grant, grant_idx, grant_valid, exp_oh, order[n]);
                end
            end
            req = req & ~exp_oh;
            @(negedge clk);
            tests_run++; if (grant_valid !== 1'b0 || grant !== 4'b0000) begin
                tests_failed++;
                $display("FAIL rotation_bubble[%0d]: got grant %b valid %b expected grant 0000 valid 0", n, grant, grant_valid);
            end
            req = (n == 4) ? 4'b0000 : 4'b1111;
        end
        @(negedge clk);
    endtask

    task automatic test_timeout();
        int n;
        int to_seen;
        n = 0;
        to_seen = 0;
        req = 4'b0100;
        @(negedge clk);
        while (grant_valid === 1'b1 && n < 20) begin
            if (timeout !== 1'b0) to_seen++;
            n++;
            @(negedge clk);
        end
        tests_run++; if (n !== 16) begin tests_failed++; $display("FAIL timeout_hold_len: got %0d cycles expected 16", n); end
        tests_run++; if (to_seen !== 0) begin tests_failed++; $display("FAIL timeout_early_pulse: got %0d pulses during hold expected 0", to_seen); end
        tests_run++; if (timeout !== 1'b1 || grant !== 4'b0000) begin
            tests_failed++; $display("FAIL timeout_pulse: got timeout %b grant %b expected timeout 1 grant 0000", timeout, grant);
        end
        @(negedge clk);
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL timeout_pulse_width: got %b expected 0", timeout); end
        tests_run++; if (grant !== 4'b0100 || grant_idx !== 2'd2) begin
            tests_failed++; $display("FAIL timeout_regrant: got grant %b idx %0d expected grant 0100 idx 2", grant, grant_idx);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_fairness();
        int n;
        do_reset();
        req = 4'b0010;
        @(negedge clk);
        tests_run++; if (grant !== 4'b0010 || grant_idx !== 2'd1) begin
            tests_failed++; $display("FAIL fair_first: got grant %b idx %0d expected grant 0010 idx 1", grant, grant_idx);
        end
        req = 4'b1010;
        n = 0;
        while (timeout !== 1'b1 && n < 20) begin
            n++;
            @(negedge clk);
        end
        tests_run++; if (timeout !== 1'b1) begin tests_failed++; $display("FAIL fair_timeout_seen: got timeout %b expected 1", timeout); end
        @(negedge clk);
        tests_run++; if (grant !== 4'b1000 || grant_idx !== 2'd3) begin
            tests_failed++; $display("FAIL fair_next_owner: got grant %b idx %0d expected grant 1000 idx 3", grant, grant_idx);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_release_at_limit();
        do_reset();
        req = 4'b0001;
        repeat (16) @(negedge clk);
        tests_run++; if (grant_valid !== 1'b1 || grant !== 4'b0001) begin
            tests_failed++; $display("FAIL limit_still_held: got grant %b valid %b expected grant 0001 valid 1", grant, grant_valid);
        end
        req = 4'b0000;
        @(negedge clk);
        tests_run++; if (grant !== 4'b0000 || grant_valid !== 1'b0) begin
            tests_failed++; $display("FAIL limit_release: got grant %b valid %b expected grant 0000 valid 0", grant, grant_valid);
        end
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL limit_no_timeout: got %b expected 0", timeout); end
        @(negedge clk);
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL limit_no_timeout_late: got %b expected 0", timeout); end
    endtask

    task automatic test_reset_mid_grant();
        do_reset();
        req = 4'b0100;
        @(negedge clk);
        tests_run++; if (grant_idx !== 2'd2 || grant_valid !== 1'b1) begin
            tests_failed++; $display("FAIL mid_rst_owner: got idx %0d valid %b expected idx 2 valid 1", grant_idx, grant_valid);
        end
        // Reset lands on the very edge that would otherwise fire the timeout.
        repeat (15) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        tests_run++; if (grant !== 4'b0000 || grant_valid !== 1'b0 || grant_idx !== 2'd0) begin
            tests_failed++; $display("FAIL mid_rst_clear: got grant %b idx %0d valid %b expected grant 0000 idx 0 valid 0", grant, grant_idx, grant_valid);
        end
        tests_run++; if (timeout !== 1'b0) begin tests_failed++; $display("FAIL mid_rst_timeout: got %b expected 0", timeout); end
        rst = 1'b0;
        req = 4'b1111;
        @(negedge clk);
        tests_run++; if (grant !== 4'b0001 || grant_idx !== 2'd0) begin
            tests_failed++; $display("FAIL mid_rst_regrant: got grant %b idx %0d expected grant 0001 idx 0", grant, grant_idx);
        end
        req = 4'b0000;
        repeat (2) @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        req = 4'b0000;
        test_reset();
        test_single();
        test_rotation();
        test_timeout();
        test_fairness();
        test_release_at_limit();
        test_reset_mid_grant();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
